theta_to_xy_cordic: RTL and testbench

Parametrised successor to the team's angle-to-coordinate converter. It turns an integer-degree angle and a runtime radius into true circular (cos, sin) coordinates, using an iterative rotation-mode CORDIC. It replaces the fixed 10-degree-step, fixed-radius diamond lookup. It sits between the card-pose/angle logic and the 3D projection stage, with valid/ready handshakes on both sides.

---
 rtl/theta_to_xy_cordic.sv | 202 ++++++++++++++++++++
 tb/tb_theta_to_xy_cordic.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/theta_to_xy_cordic.sv
// Integer-degree angle + radius to (r*cos, r*sin) via iterative rotation-mode CORDIC.
// Result valid ITERS+2 cycles after accept; one request in flight, held in DONE until ready_in.
module theta_to_xy_cordic #(
    parameter int WIDTH = 8,
    parameter int ITERS = 12,
    parameter int GUARD = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [8:0]              angle_in,
    input  logic [WIDTH-2:0]        radius_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    valid_out,
    input  logic                    ready_in
);
    localparam int XW = WIDTH + GUARD + 2;
    localparam int ZW = 25;
    localparam int PW = WIDTH + 15;
    localparam int IW = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [PW-1:0]        K_GAIN     = PW'(39797);
    localparam logic signed [XW-1:0] SAT_MAX    = XW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN    = -SAT_MAX;
    localparam logic signed [XW-1:0] ROUND_BIAS = XW'(1 << (GUARD - 1));

    // round(atan(2^-i) in degrees * 2^16)
    function automatic logic signed [ZW-1:0] atan_lut(input logic [IW-1:0] i);
        atan_lut = '0;
        case (i)
            4'd0:  atan_lut = 25'sd2949120;
            4'd1:  atan_lut = 25'sd1740967;
            4'd2:  atan_lut = 25'sd919879;
            4'd3:  atan_lut = 25'sd466945;
            4'd4:  atan_lut = 25'sd234379;
            4'd5:  atan_lut = 25'sd117304;
            4'd6:  atan_lut = 25'sd58666;
            4'd7:  atan_lut = 25'sd29335;
            4'd8:  atan_lut = 25'sd14668;
            4'd9:  atan_lut = 25'sd7334;
            4'd10: atan_lut = 25'sd3667;
            4'd11: atan_lut = 25'sd1833;
            4'd12: atan_lut = 25'sd917;
            4'd13: atan_lut = 25'sd458;
            4'd14: atan_lut = 25'sd229;
            4'd15: atan_lut = 25'sd115;
            default: atan_lut = '0;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
        else                  sat = v[WIDTH-1:0];
    endfunction

    logic [1:0]              state_q, state_d;
    logic [8:0]              angle_q, angle_d;
    logic [WIDTH-2:0]        radius_q, radius_d;
    logic                    neg_q, neg_d;
    logic [IW-1:0]           iter_q, iter_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]    z_q, z_d;
    logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic                    valid_out_q, valid_out_d;

    logic signed [9:0]       a_red, a_fold;
    logic                    neg_fold;
    logic [PW-1:0]           prod;
    logic [XW-1:0]           x_mag;
    logic signed [XW-1:0]    x_init;
    logic signed [ZW-1:0]    z_init;
    logic signed [XW-1:0]    x_it, y_it, x_fin, y_fin, x_rnd, y_rnd;
    logic signed [ZW-1:0]    z_it;

    // Fold the latched angle into [-90,90]; neg remembers a 180-degree flip.
    always_comb begin
        a_red = $signed({1'b0, angle_q});
        if (angle_q >= 9'd360) a_red = $signed({1'b0, angle_q}) - 10'sd360;
        a_fold   = a_red;
        neg_fold = 1'b0;
        if (a_red > 10'sd90 && a_red < 10'sd270) begin
            a_fold   = a_red - 10'sd180;
            neg_fold = 1'b1;
        end else if (a_red >= 10'sd270) begin
            a_fold = a_red - 10'sd360;
        end
        z_init = ZW'(a_fold);
        z_init = z_init <<< 16;
        prod   = PW'(radius_q) * K_GAIN;
        x_mag  = XW'(prod >> 16);
        x_init = $signed(x_mag << GUARD);
    end

    always_comb begin
        if (!z_q[ZW-1]) begin
            x_it = x_q - (y_q >>> iter_q);
            y_it = y_q + (x_q >>> iter_q);
            z_it = z_q - atan_lut(iter_q);
        end else begin
            x_it = x_q + (y_q >>> iter_q);
            y_it = y_q - (x_q >>> iter_q);
            z_it = z_q + atan_lut(iter_q);
        end
        x_fin = neg_q ? -x_it : x_it;
        y_fin = neg_q ? -y_it : y_it;
        x_rnd = (x_fin + ROUND_BIAS) >>> GUARD;
        y_rnd = (y_fin + ROUND_BIAS) >>> GUARD;
    end

    always_comb begin
        state_d     = state_q;
        angle_d     = angle_q;
        radius_d    = radius_q;
        neg_d       = neg_q;
        iter_d      = iter_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        valid_out_d = valid_out_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    angle_d  = angle_in;
                    radius_d = radius_in;
                    state_d  = PREP;
                end
            end
            PREP: begin
                x_d     = x_init;
                y_d     = '0;
                z_d     = z_init;
                neg_d   = neg_fold;
                iter_d  = '0;
                state_d = ITER;
            end
            ITER: begin
                x_d = x_it;
                y_d = y_it;
                z_d = z_it;
                if (iter_q == IW'(ITERS - 1)) begin
                    x_out_d     = sat(x_rnd);
                    y_out_d     = sat(y_rnd);
                    valid_out_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_in) begin
                    valid_out_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            angle_q     <= '0;
            radius_q    <= '0;
            neg_q       <= 1'b0;
            iter_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            radius_q    <= radius_d;
            neg_q       <= neg_d;
            iter_q      <= iter_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign ready_out = (state_q == IDLE) && !rst_in;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = '0;
    assign valid_out = valid_out_q;
endmodule

// File: tb/tb_theta_to_xy_cordic.sv
// Directed bench for theta_to_xy_cordic (WIDTH=8, ITERS=12, GUARD=4).
module tb_theta_to_xy_cordic;
    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [8:0]        angle_in;
    logic [6:0]        radius_in;
    logic              valid_in;
    logic              ready_out;
    logic signed [7:0] x_out, y_out, z_out;
    logic              valid_out;
    logic              ready_in;

    int checks = 0;
    int errors = 0;

    theta_to_xy_cordic #(.WIDTH(8), .ITERS(12), .GUARD(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .angle_in(angle_in), .radius_in(radius_in),
        .valid_in(valid_in), .ready_out(ready_out), .x_out(x_out), .y_out(y_out),
        .z_out(z_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        checks++;
        assert ((obs >= exp - 1) && (obs <= exp + 1)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after accept, wait for result; lat counts the accept cycle as 1.
    task automatic request(input logic [8:0] ang, input logic [6:0] rad, output int lat);
        int guard_cnt;
        guard_cnt = 0;
        while (!ready_out && guard_cnt < 50) begin
            tick();
            guard_cnt++;
        end
        valid_in  = 1'b1;
        angle_in  = ang;
        radius_in = rad;
        tick();
        valid_in  = 1'b0;
        angle_in  = ang ^ 9'h155;
        radius_in = ~rad;
        lat = 1;
        while (!valid_out && lat < 40) begin
            tick();
            lat++;
        end
        if (!valid_out) begin
            errors++;
            $display("FAIL timeout angle=%0d observed=no result expected=valid_out", ang);
        end
    endtask

    task automatic ack();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic vec(input string tag, input logic [8:0] ang, input logic [6:0] rad,
                       input int ex, input int ey);
        int lat;
        request(ang, rad, lat);
        check_near({tag, "_x"}, int'(x_out), ex);
        check_near({tag, "_y"}, int'(y_out), ey);
        ack();
    endtask

    initial begin
        int lat;
        int hx, hy;
        int seen;
        rst_in    = 1'b1;
        valid_in  = 1'b0;
        ready_in  = 1'b0;
        angle_in  = '0;
        radius_in = '0;
        tick();
        tick();
        check_eq("rst_ready", int'(ready_out), 0);
        check_eq("rst_valid", int'(valid_out), 0);
        check_eq("rst_x", int'(x_out), 0);
        check_eq("rst_y", int'(y_out), 0);
        check_eq("rst_z", int'(z_out), 0);
        rst_in = 1'b0;
        #1;
        check_eq("ready_after_rst", int'(ready_out), 1);

        // Cardinal angles and latency
        request(9'd0, 7'd48, lat);
        check_eq("latency", lat, 14);
        check_near("a0_x", int'(x_out), 48);
        check_near("a0_y", int'(y_out), 0);
        check_eq("z_zero", int'(z_out), 0);
        ack();
        vec("a90", 9'd90, 7'd48, 0, 48);
        vec("a180", 9'd180, 7'd48, -48, 0);
        vec("a270", 9'd270, 7'd48, 0, -48);

        vec("a45", 9'd45, 7'd48, 34, 34);
        vec("a30", 9'd30, 7'd48, 42, 24);
        vec("a225", 9'd225, 7'd48, -34, -34);
        vec("a359", 9'd359, 7'd48, 48, -1);
        vec("a400", 9'd400, 7'd48, 37, 31);
        vec("a511", 9'd511, 7'd48, -42, 23);
        vec("r127", 9'd0, 7'd127, 127, 0);
        vec("r0_a0", 9'd0, 7'd0, 0, 0);
        vec("r0_a137", 9'd137, 7'd0, 0, 0);

        // ready_in while idle must not do anything
        ready_in = 1'b1;
        tick();
        tick();
        ready_in = 1'b0;
        check_eq("idle_rdyin_valid", int'(valid_out), 0);
        check_eq("idle_rdyin_ready", int'(ready_out), 1);

        // Backpressure: hold the result for 20 cycles
        request(9'd45, 7'd48, lat);
        hx = int'(x_out);
        hy = int'(y_out);
        check_near("hold_x0", hx, 34);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("hold_valid", int'(valid_out), 1);
            check_eq("hold_ready", int'(ready_out), 0);
            check_eq("hold_x", int'(x_out), hx);
            check_eq("hold_y", int'(y_out), hy);
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check_eq("hs_valid_fall", int'(valid_out), 0);
        check_eq("hs_ready_rise", int'(ready_out), 1);

        // Second request mid-ITER is dropped
        valid_in  = 1'b1;
        angle_in  = 9'd90;
        radius_in = 7'd48;
        tick();
        valid_in  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        valid_in  = 1'b1;
        angle_in  = 9'd180;
        radius_in = 7'd100;
        tick();
        valid_in  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_out) begin
                seen++;
                check_near("drop_x", int'(x_out), 0);
                check_near("drop_y", int'(y_out), 48);
                ready_in = 1'b1;
            end
            tick();
            ready_in = 1'b0;
        end
        check_eq("drop_count", seen, 1);

        // Reset mid-ITER aborts the request
        request(9'd30, 7'd48, lat);
        ack();
        valid_in  = 1'b1;
        angle_in  = 9'd0;
        radius_in = 7'd100;
        tick();
        valid_in  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1;
        check_eq("abort_valid", int'(valid_out), 0);
        check_eq("abort_x", int'(x_out), 0);
        check_eq("abort_y", int'(y_out), 0);
        check_eq("abort_ready", int'(ready_out), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_out) seen++;
        end
        check_eq("abort_no_result", seen, 0);
        vec("a60", 9'd60, 7'd48, 24, 42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
